// File: rtl/sram_arbiter.sv
// Two-client SRAM arbiter: independent round-robin read/write ports, same-address read stall; optional counters via SRAM_ARBITER_PERF_EN.
// Latency: grants are combinational in the request cycle; read responses return readLatency cycles after the read grant.
// Backpressure: a client is held off by deasserting its ready; losers and conflict-stalled reads simply retry on a later cycle.
module sram_arbiter #(
    parameter int width         = 16,
    parameter int logDepth      = 9,
    parameter int logLineOffset = 3,
    parameter int readLatency   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef SRAM_ARBITER_PERF_EN
    output logic [31:0]              perf_rd_grants,
    output logic [31:0]              perf_wr_grants,
    output logic [31:0]              perf_conflict_stalls,
`endif
    input  logic                     c0_valid,
    input  logic                     c0_write,
    input  logic [logDepth-1:0]      c0_addr,
    input  logic [logLineOffset-1:0] c0_offset,
    input  logic [width-1:0]         c0_wdata,
    output logic                     c0_ready,
    output logic                     c0_rvalid,
    output logic [width-1:0]         c0_rdata,
    input  logic                     c1_valid,
    input  logic                     c1_write,
    input  logic [logDepth-1:0]      c1_addr,
    input  logic [logLineOffset-1:0] c1_offset,
    input  logic [width-1:0]         c1_wdata,
    output logic                     c1_ready,
    output logic                     c1_rvalid,
    output logic [width-1:0]         c1_rdata,
    output logic [width-1:0]         sram_writeData,
    output logic [logDepth-1:0]      sram_writeAddr,
    output logic [logDepth-1:0]      sram_readAddr,
    output logic [logLineOffset-1:0] sram_writeOffset,
    output logic                     sram_writeEnable,
    input  logic [width-1:0]         sram_readData
);

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    logic wr_ptr, rd_ptr;
    logic wr_gnt, wr_id, rd_cand, rd_id, rd_gnt, conflict;
    logic [logDepth-1:0] wr_addr, rd_addr;
    tag_t tag_pipe [readLatency];

    always_comb begin
        wr_gnt   = 1'b0;
        wr_id    = 1'b0;
        rd_cand  = 1'b0;
        rd_id    = 1'b0;
        rd_gnt   = 1'b0;
        conflict = 1'b0;
        if (!reset) begin
            if ((c0_valid && c0_write) && (c1_valid && c1_write)) begin
                wr_gnt = 1'b1;
                wr_id  = wr_ptr;
            end else if (c0_valid && c0_write) begin
                wr_gnt = 1'b1;
            end else if (c1_valid && c1_write) begin
                wr_gnt = 1'b1;
                wr_id  = 1'b1;
            end
            if ((c0_valid && !c0_write) && (c1_valid && !c1_write)) begin
                rd_cand = 1'b1;
                rd_id   = rd_ptr;
            end else if (c0_valid && !c0_write) begin
                rd_cand = 1'b1;
            end else if (c1_valid && !c1_write) begin
                rd_cand = 1'b1;
                rd_id   = 1'b1;
            end
        end
        wr_addr = wr_id ? c1_addr : c0_addr;
        rd_addr = rd_id ? c1_addr : c0_addr;
        // A read racing a write to the same line waits so it observes the new data.
        conflict = wr_gnt && rd_cand && (rd_addr == wr_addr);
        rd_gnt   = rd_cand && !conflict;
    end

    assign c0_ready = (wr_gnt && !wr_id) || (rd_gnt && !rd_id);
    assign c1_ready = (wr_gnt &&  wr_id) || (rd_gnt &&  rd_id);

    assign sram_writeEnable = wr_gnt;
    assign sram_writeAddr   = wr_gnt ? wr_addr : '0;
    assign sram_writeOffset = wr_gnt ? (wr_id ? c1_offset : c0_offset) : '0;
    assign sram_writeData   = wr_gnt ? (wr_id ? c1_wdata : c0_wdata) : '0;
    assign sram_readAddr    = rd_gnt ? rd_addr : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int k = 0; k < readLatency; k++) tag_pipe[k] <= '0;
        end else begin
            if (wr_gnt) wr_ptr <= ~wr_id;
            if (rd_gnt) rd_ptr <= ~rd_id;
            tag_pipe[0] <= '{vld: rd_gnt, id: rd_id};
            for (int k = 1; k < readLatency; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign c0_rvalid = tag_pipe[readLatency-1].vld && !tag_pipe[readLatency-1].id;
    assign c1_rvalid = tag_pipe[readLatency-1].vld &&  tag_pipe[readLatency-1].id;
    assign c0_rdata  = c0_rvalid ? sram_readData : '0;
    assign c1_rdata  = c1_rvalid ? sram_readData : '0;

`ifdef SRAM_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_grants       <= '0;
            perf_wr_grants       <= '0;
            perf_conflict_stalls <= '0;
        end else begin
            if (rd_gnt)   perf_rd_grants       <= perf_rd_grants + 32'd1;
            if (wr_gnt)   perf_wr_grants       <= perf_wr_grants + 32'd1;
            if (conflict) perf_conflict_stalls <= perf_conflict_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a cycle-indexed reference model, with an SRAM model of matching read latency.
module tb_sram_arbiter;
    localparam int W = 16;
    localparam int D = 9;
    localparam int O = 3;
    localparam int L = 3;

    logic clk = 1'b0;
    logic reset;
    logic c0_valid, c0_write, c1_valid, c1_write;
    logic [D-1:0] c0_addr, c1_addr;
    logic [O-1:0] c0_offset, c1_offset;
    logic [W-1:0] c0_wdata, c1_wdata;
    logic c0_ready, c1_ready, c0_rvalid, c1_rvalid;
    logic [W-1:0] c0_rdata, c1_rdata;
    logic [W-1:0] sram_writeData, sram_readData;
    logic [D-1:0] sram_writeAddr, sram_readAddr;
    logic [O-1:0] sram_writeOffset;
    logic sram_writeEnable;
`ifdef SRAM_ARBITER_PERF_EN
    logic [31:0] perf_rd_grants, perf_wr_grants, perf_conflict_stalls;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(.width(W), .logDepth(D), .logLineOffset(O), .readLatency(L)) dut (
        .clk(clk), .reset(reset),
`ifdef SRAM_ARBITER_PERF_EN
        .perf_rd_grants(perf_rd_grants), .perf_wr_grants(perf_wr_grants),
        .perf_conflict_stalls(perf_conflict_stalls),
`endif
        .c0_valid(c0_valid), .c0_write(c0_write), .c0_addr(c0_addr), .c0_offset(c0_offset),
        .c0_wdata(c0_wdata), .c0_ready(c0_ready), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_valid(c1_valid), .c1_write(c1_write), .c1_addr(c1_addr), .c1_offset(c1_offset),
        .c1_wdata(c1_wdata), .c1_ready(c1_ready), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .sram_writeData(sram_writeData), .sram_writeAddr(sram_writeAddr),
        .sram_readAddr(sram_readAddr), .sram_writeOffset(sram_writeOffset),
        .sram_writeEnable(sram_writeEnable), .sram_readData(sram_readData)
    );

    // SRAM: data for an address presented in cycle t appears at cycle t+L.
    logic [W-1:0] smem [0:(1<<D)-1];
    logic [W-1:0] rd_pipe [L];
    always @(posedge clk) begin
        if (sram_writeEnable) smem[sram_writeAddr] <= sram_writeData;
        rd_pipe[0] <= smem[sram_readAddr];
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_readData = rd_pipe[L-1];

    // Reference model state: memory contents, pointers and responses scheduled by absolute cycle.
    bit [W-1:0] mmem [0:(1<<D)-1];
    int  wptr, rptr;
    bit  exp_v [64];
    int  exp_c [64];
    bit [W-1:0] exp_d [64];
    int  n_rd, n_wr, n_stall;
    int  tests, fails, cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int c, input bit v, input bit wr, input int a, input int d);
        logic [D-1:0] av;
        logic [W-1:0] dv;
        av = a[D-1:0];
        dv = d[W-1:0];
        if (c == 0) begin
            c0_valid = v; c0_write = wr; c0_addr = av; c0_wdata = dv;
            c0_offset = O'($urandom_range(0, (1<<O)-1));
        end else begin
            c1_valid = v; c1_write = wr; c1_addr = av; c1_wdata = dv;
            c1_offset = O'($urandom_range(0, (1<<O)-1));
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic step();
        int ww, rw, wa, ra, s;
        bit wq0, wq1, rq0, rq1;
        bit [W-1:0] wd;
        bit [O-1:0] wo;
        @(negedge clk);
        ww = -1; rw = -1;
        wq0 = c0_valid && c0_write;  wq1 = c1_valid && c1_write;
        rq0 = c0_valid && !c0_write; rq1 = c1_valid && !c1_write;
        if (!reset) begin
            if (wq0 && wq1) ww = wptr; else if (wq0) ww = 0; else if (wq1) ww = 1;
            if (rq0 && rq1) rw = rptr; else if (rq0) rw = 0; else if (rq1) rw = 1;
        end
        wa = (ww == 1) ? int'(c1_addr) : int'(c0_addr);
        ra = (rw == 1) ? int'(c1_addr) : int'(c0_addr);
        wd = (ww == 1) ? c1_wdata : c0_wdata;
        wo = (ww == 1) ? c1_offset : c0_offset;
        if (ww >= 0 && rw >= 0 && wa == ra) begin
            rw = -1;
            n_stall++;
        end
        check("c0_ready", c0_ready, (ww == 0) || (rw == 0));
        check("c1_ready", c1_ready, (ww == 1) || (rw == 1));
        check("sram_we", sram_writeEnable, ww >= 0);
        check("sram_waddr", sram_writeAddr, ww >= 0 ? wa : 0);
        check("sram_woff", sram_writeOffset, ww >= 0 ? wo : 0);
        check("sram_wdata", sram_writeData, ww >= 0 ? wd : 0);
        check("sram_raddr", sram_readAddr, rw >= 0 ? ra : 0);
        s = cyc % 64;
        if (!reset) begin
            check("c0_rvalid", c0_rvalid, exp_v[s] && exp_c[s] == 0);
            check("c1_rvalid", c1_rvalid, exp_v[s] && exp_c[s] == 1);
            check("c0_rdata", c0_rdata, (exp_v[s] && exp_c[s] == 0) ? exp_d[s] : 0);
            check("c1_rdata", c1_rdata, (exp_v[s] && exp_c[s] == 1) ? exp_d[s] : 0);
        end
        exp_v[s] = 0;
        if (rw >= 0) begin
            s = (cyc + L) % 64;
            exp_v[s] = 1; exp_c[s] = rw; exp_d[s] = mmem[ra];
            rptr = 1 - rw;
            n_rd++;
        end
        if (ww >= 0) begin
            mmem[wa] = wd;
            wptr = 1 - ww;
            n_wr++;
        end
        if (reset) begin
            wptr = 0; rptr = 0;
            n_rd = 0; n_wr = 0; n_stall = 0;
            for (int k = 0; k < 64; k++) exp_v[k] = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        wptr = 0; rptr = 0; n_rd = 0; n_wr = 0; n_stall = 0;
        for (int k = 0; k < 64; k++) exp_v[k] = 0;
        reset = 1'b1;
        idle();
        @(posedge clk); #1;
        cyc++;
        // Requests during reset must be ignored.
        drive(0, 1, 0, 3, 0);
        drive(1, 1, 1, 4, 16'h1234);
        step();
        step();
        reset = 1'b0;

        // Initialise the low lines so every later read has a known value.
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 1, a, int'($urandom_range(0, 16'hffff)));
            drive(1, 0, 0, 0, 0);
            step();
        end

        // Lone read of line 5.
        idle();
        drive(0, 1, 0, 5, 0);
        step();
        idle();
        for (int k = 0; k < L + 1; k++) step();

        // Both clients reading continuously alternate.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, k, 0);
            drive(1, 1, 0, 8 + k, 0);
            step();
        end
        idle();
        for (int k = 0; k < L + 1; k++) step();

        // Write and read of line 7 in one cycle: read waits and sees new data.
        drive(0, 1, 1, 7, 16'hbeef);
        drive(1, 1, 0, 7, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        idle();
        for (int k = 0; k < L + 1; k++) step();

        // Write and read of different lines both granted.
        drive(0, 1, 1, 9, 16'h5a5a);
        drive(1, 1, 0, 2, 0);
        step();
        idle();
        for (int k = 0; k < L + 1; k++) step();

        // Reset with a read in flight: response dropped, pointers back to client 0.
        drive(0, 1, 0, 3, 0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1, 0, 4, 0);
        drive(1, 1, 0, 6, 0);
        step();
        drive(0, 1, 1, 10, 16'h0f0f);
        drive(1, 1, 1, 11, 16'hf0f0);
        step();
        idle();
        for (int k = 0; k < L + 2; k++) step();

        // Random traffic over a small address window to provoke contention and conflicts.
        for (int n = 0; n < 1500; n++) begin
            drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 16'hffff)));
            drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 16'hffff)));
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        for (int k = 0; k < L + 1; k++) step();

`ifdef SRAM_ARBITER_PERF_EN
        check("perf_rd", perf_rd_grants, n_rd);
        check("perf_wr", perf_wr_grants, n_wr);
        check("perf_stall", perf_conflict_stalls, n_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 16, SRAM line width in bits.
REQ-002 The block SHALL have parameter logDepth, default 9, SRAM address width.
REQ-003 The block SHALL have parameter logLineOffset, default 3, write-offset width.
REQ-004 The block SHALL have parameter readLatency, default 1, legal range 1..8: cycles from read grant to readData valid at the SRAM.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 For each client i in {0,1}, the block SHALL have port ci_valid, input, 1 bit, request present.
REQ-008 For each client i, the block SHALL have port ci_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 For each client i, the block SHALL have ports ci_addr (input, logDepth), ci_offset (input, logLineOffset) and ci_wdata (input, width).
REQ-010 For each client i, the block SHALL have port ci_ready, output, 1 bit, request accepted this cycle.
REQ-011 For each client i, the block SHALL have ports ci_rvalid (output, 1) and ci_rdata (output, width), carrying the read response.
REQ-012 The block SHALL have outputs sram_writeData (width), sram_writeAddr (logDepth), sram_readAddr (logDepth), sram_writeOffset (logLineOffset) and sram_writeEnable (1), plus input sram_readData (width).

Function
REQ-013 A request SHALL be accepted in a cycle where ci_valid && ci_ready; ci_ready SHALL be combinational from current inputs and state.
REQ-014 Read and write ports SHALL be arbitrated independently; at most one read and one write are granted per cycle.
REQ-015 Each port SHALL keep a round-robin pointer; on contention, the client named by the pointer wins; after any grant on that port, the pointer SHALL name the other client.
REQ-016 An uncontended request SHALL be granted in the same cycle regardless of the pointer.
REQ-017 If the granted write and the candidate read target the same address in one cycle, the read SHALL NOT be granted; it retries next cycle, and the read pointer SHALL NOT change.
REQ-018 A write grant SHALL drive sram_writeEnable=1 and sram_writeAddr/Offset/Data from the winner in the same cycle; otherwise sram_writeEnable=0 and other SRAM outputs are 0.
REQ-019 A read grant SHALL drive sram_readAddr from the winner; otherwise sram_readAddr=0.
REQ-020 A tag shift register of depth readLatency SHALL carry {valid, client id} per read grant.
REQ-021 ci_rvalid SHALL pulse exactly readLatency cycles after the grant, with ci_rdata=sram_readData; at most one ci_rvalid per cycle across clients.
REQ-022 ci_rdata SHALL be 0 when ci_rvalid=0.
REQ-023 Back-to-back read grants every cycle SHALL be sustained with no bubbles.

Reset
REQ-024 While reset=1: all ci_ready=0, sram_writeEnable=0, all SRAM outputs 0, and no grants.
REQ-025 On reset, both round-robin pointers SHALL be set to client 0 and the tag pipe SHALL be cleared; ci_rvalid=0 starting the cycle after reset is sampled.
REQ-026 Reads in flight at reset SHALL be dropped, producing no response after reset.

Configuration
REQ-027 With macro SRAM_ARBITER_PERF_EN defined, the block SHALL add 32-bit wrapping output counters perf_rd_grants, perf_wr_grants and perf_conflict_stalls, cleared by reset and incremented once per qualifying cycle.
REQ-028 Without SRAM_ARBITER_PERF_EN, those ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Reset, then c0 read of addr 5 alone -> c0_ready=1 the same cycle; c0_rvalid=1 exactly readLatency cycles later with mem[5].
REQ-030 c0 and c1 both reading continuously for 4 cycles -> grants alternate c0,c1,c0,c1; responses return in the same order.
REQ-031 c0 writes addr 7 while c1 reads addr 7 in the same cycle -> write granted, read stalled one cycle; c1 data is the new value (perf_conflict_stalls=1 with SRAM_ARBITER_PERF_EN).
REQ-032 c0 write and c1 read to different addresses in the same cycle -> both ready=1 the same cycle.
REQ-033 With readLatency=3, reset asserted one cycle after a read grant -> no ci_rvalid after reset; pointers back at client 0.
